// File: rtl/qcom_pkg.sv
// Shared definitions for the QCOM receive-side command processor.
//   - Header codes of the PMOD link packets.
//   - qcom_cmd_t: one queued command {op, sel, dt} as presented to the core.
//   - sync_st_t: SYNC delay FSM states (only used when QCOM_SYNC_DLY_EN is defined).
package qcom_pkg;

  localparam logic [2:0] H_CLR_FLG = 3'b000;
  localparam logic [2:0] H_SET_FLG = 3'b001;
  localparam logic [2:0] H_DT8     = 3'b010;
  localparam logic [2:0] H_SYNC    = 3'b011;
  localparam logic [2:0] H_DT16    = 3'b100;
  localparam logic [2:0] H_DT32    = 3'b110;

  typedef struct packed {
    logic [2:0]  op;
    logic        sel;
    logic [31:0] dt;
  } qcom_cmd_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } sync_st_t;

endpackage

// File: rtl/qcom_cmd_proc_if.sv
// Packet-in / command-out bus of qcom_cmd_proc.
//   rx_vld_i, rx_header_i, rx_data_i : decoded packet from the link receiver
//   cmd_vld_o, cmd_rdy_i             : valid/ready handshake toward the core
//   cmd_op_o, cmd_sel_o, cmd_dt_o    : head entry of the command queue
// Modport slave is the processor side, master is the environment side.
interface qcom_cmd_proc_if;

  logic        rx_vld_i;
  logic [2:0]  rx_header_i;
  logic [32:0] rx_data_i;
  logic        cmd_vld_o;
  logic        cmd_rdy_i;
  logic [2:0]  cmd_op_o;
  logic        cmd_sel_o;
  logic [31:0] cmd_dt_o;

  modport slave (
    input  rx_vld_i, rx_header_i, rx_data_i, cmd_rdy_i,
    output cmd_vld_o, cmd_op_o, cmd_sel_o, cmd_dt_o
  );

  modport master (
    output rx_vld_i, rx_header_i, rx_data_i, cmd_rdy_i,
    input  cmd_vld_o, cmd_op_o, cmd_sel_o, cmd_dt_o
  );

endinterface

// File: rtl/qcom_cmd_fifo.sv
// First-word-fall-through FIFO of qcom_cmd_t.
//   c_clk_i, c_rst_ni : clock, asynchronous active-low reset
//   clr_i             : synchronous flush (wins over push/pop)
//   push, din         : write request; accepted when not full, or when full and popping
//   pop               : read request; ignored when empty
//   dout              : head entry, all zeros while empty
//   full, empty       : occupancy flags
module qcom_cmd_fifo
  import qcom_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      c_clk_i,
  input  logic      c_rst_ni,
  input  logic      clr_i,
  input  logic      push,
  input  logic      pop,
  input  qcom_cmd_t din,
  output qcom_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0] wr_ptr, rd_ptr;
  qcom_cmd_t   mem [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge c_clk_i) begin
    if (do_push && !clr_i) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/qcom_cmd_proc.sv
// Receive-side QCOM command processor.
// Decodes each packet from the link receiver, updates the QCOM flag, the two
// data registers and the SYNC pulse logic, queues accepted commands for the
// core and keeps saturating rx/error/drop statistics.
//
// Ports:
//   c_clk_i, c_rst_ni  : core clock, asynchronous active-low reset
//   clr_i              : synchronous clear of all state; a packet in the same cycle is ignored
//   sync_dly_cfg       : SYNC delay in cycles (only with QCOM_SYNC_DLY_EN)
//   bus (slave)        : packet input and valid/ready command output
//   qflag_o            : QCOM flag
//   qreg1_o, qreg2_o   : data registers selected by sel=0 / sel=1
//   sync_o             : one-cycle SYNC pulse
//   rx_cnt_o, err_cnt_o, drop_cnt_o : saturating statistics
//
// Build option QCOM_SYNC_DLY_EN: when defined, sync_o fires sync_dly_cfg+1
// cycles after a SYNC packet (retriggerable); otherwise it fires 1 cycle after.
//
// SYNC FSM (QCOM_SYNC_DLY_EN only)
//   state  | meaning
//   S_IDLE | no pulse pending
//   S_WAIT | counting down; pulse issued on the cycle after cnt reaches 1
module qcom_cmd_proc
  import qcom_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             c_clk_i,
  input  logic             c_rst_ni,
  input  logic             clr_i,
  input  logic [7:0]       sync_dly_cfg,
  qcom_cmd_proc_if.slave   bus,
  output logic             qflag_o,
  output logic [31:0]      qreg1_o,
  output logic [31:0]      qreg2_o,
  output logic             sync_o,
  output logic [CNT_W-1:0] rx_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  logic        hdr_ok;
  logic        sel;
  logic [31:0] dt;
  logic        rx_acc, cmd_ok, cmd_bad, wr_reg, sync_cmd;
  logic        pop, drop, fifo_full, fifo_empty;
  qcom_cmd_t   push_cmd, head_cmd;

  always_comb begin
    hdr_ok = 1'b1;
    sel    = 1'b0;
    dt     = '0;
    case (bus.rx_header_i)
      H_CLR_FLG, H_SET_FLG: ;
      H_DT8: begin
        sel = bus.rx_data_i[8];
        dt  = {24'd0, bus.rx_data_i[7:0]};
      end
      H_SYNC: sel = bus.rx_data_i[8];
      H_DT16: begin
        sel = bus.rx_data_i[17];
        dt  = {16'd0, bus.rx_data_i[15:0]};
      end
      H_DT32: begin
        sel = bus.rx_data_i[32];
        dt  = bus.rx_data_i[31:0];
      end
      default: hdr_ok = 1'b0;
    endcase
  end

  assign rx_acc   = bus.rx_vld_i & ~clr_i;
  assign cmd_ok   = rx_acc & hdr_ok;
  assign cmd_bad  = rx_acc & ~hdr_ok;
  assign wr_reg   = cmd_ok & ((bus.rx_header_i == H_DT8) | (bus.rx_header_i == H_DT16) |
                              (bus.rx_header_i == H_DT32));
  assign sync_cmd = cmd_ok & (bus.rx_header_i == H_SYNC);

  assign pop      = bus.cmd_vld_o & bus.cmd_rdy_i;
  // A full queue still takes the new command when the head leaves in the same cycle.
  assign drop     = cmd_ok & fifo_full & ~pop;
  assign push_cmd = '{op: bus.rx_header_i, sel: sel, dt: dt};

  qcom_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .c_clk_i (c_clk_i),
    .c_rst_ni(c_rst_ni),
    .clr_i   (clr_i),
    .push    (cmd_ok),
    .pop     (pop),
    .din     (push_cmd),
    .dout    (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.cmd_vld_o = ~fifo_empty;
  assign bus.cmd_op_o  = head_cmd.op;
  assign bus.cmd_sel_o = head_cmd.sel;
  assign bus.cmd_dt_o  = head_cmd.dt;

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      qflag_o    <= 1'b0;
      qreg1_o    <= '0;
      qreg2_o    <= '0;
      rx_cnt_o   <= '0;
      err_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else if (clr_i) begin
      qflag_o    <= 1'b0;
      qreg1_o    <= '0;
      qreg2_o    <= '0;
      rx_cnt_o   <= '0;
      err_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (cmd_ok && bus.rx_header_i == H_CLR_FLG) qflag_o <= 1'b0;
      if (cmd_ok && bus.rx_header_i == H_SET_FLG) qflag_o <= 1'b1;
      if (wr_reg && !sel) qreg1_o <= dt;
      if (wr_reg && sel)  qreg2_o <= dt;
      if (cmd_ok  && rx_cnt_o   != '1) rx_cnt_o   <= rx_cnt_o   + CNT_W'(1);
      if (cmd_bad && err_cnt_o  != '1) err_cnt_o  <= err_cnt_o  + CNT_W'(1);
      if (drop    && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
    end
  end

`ifdef QCOM_SYNC_DLY_EN
  sync_st_t   st_q, st_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sync_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sync_d = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (sync_cmd) begin
          if (sync_dly_cfg == 8'd0) begin
            sync_d = 1'b1;
          end else begin
            cnt_d = sync_dly_cfg;
            st_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A new SYNC restarts the wait so only one pulse comes out.
        if (sync_cmd) begin
          if (sync_dly_cfg == 8'd0) begin
            sync_d = 1'b1;
            cnt_d  = '0;
            st_d   = S_IDLE;
          end else begin
            cnt_d = sync_dly_cfg;
          end
        end else if (cnt_q == 8'd1) begin
          sync_d = 1'b1;
          cnt_d  = '0;
          st_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      sync_o <= 1'b0;
    end else if (clr_i) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      sync_o <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sync_o <= sync_d;
    end
  end
`else
  logic unused_sync_dly;
  assign unused_sync_dly = ^sync_dly_cfg;

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni)   sync_o <= 1'b0;
    else if (clr_i)  sync_o <= 1'b0;
    else             sync_o <= sync_cmd;
  end
`endif

endmodule

// File: tb/tb_qcom_cmd_proc.sv
// Self-checking bench for qcom_cmd_proc: directed scenarios followed by random
// traffic, compared against a behavioural model; queued commands are checked
// by a scoreboard monitor on the valid/ready output.
module tb_qcom_cmd_proc;
  import qcom_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          c_clk_i = 1'b0;
  logic          c_rst_ni = 1'b0;
  logic          clr_i = 1'b0;
  logic [7:0]    sync_dly_cfg = 8'd0;
  logic          qflag_o, sync_o;
  logic [31:0]   qreg1_o, qreg2_o;
  logic [CW-1:0] rx_cnt_o, err_cnt_o, drop_cnt_o;

  qcom_cmd_proc_if bus();

  qcom_cmd_proc #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .c_clk_i     (c_clk_i),
    .c_rst_ni    (c_rst_ni),
    .clr_i       (clr_i),
    .sync_dly_cfg(sync_dly_cfg),
    .bus         (bus),
    .qflag_o     (qflag_o),
    .qreg1_o     (qreg1_o),
    .qreg2_o     (qreg2_o),
    .sync_o      (sync_o),
    .rx_cnt_o    (rx_cnt_o),
    .err_cnt_o   (err_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 c_clk_i = ~c_clk_i;

  int          checks = 0;
  int          errors = 0;
  qcom_cmd_t   exp_q[$];
  bit          m_flag;
  logic [31:0] m_r1, m_r2;
  int          m_rx, m_err, m_drop, m_occ;
  longint      m_due = -1;
  longint      cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic model_reset();
    m_flag = 1'b0; m_r1 = '0; m_r2 = '0;
    m_rx = 0; m_err = 0; m_drop = 0; m_occ = 0;
    m_due = -1;
    exp_q.delete();
  endtask

  task automatic check_state();
    chk("qflag",    64'(qflag_o),       64'(m_flag));
    chk("qreg1",    64'(qreg1_o),       64'(m_r1));
    chk("qreg2",    64'(qreg2_o),       64'(m_r2));
    chk("rx_cnt",   64'(rx_cnt_o),      64'(m_rx));
    chk("err_cnt",  64'(err_cnt_o),     64'(m_err));
    chk("drop_cnt", 64'(drop_cnt_o),    64'(m_drop));
    chk("sync",     64'(sync_o),        64'(m_due == cyc));
    chk("cmd_vld",  64'(bus.cmd_vld_o), 64'(m_occ > 0));
  endtask

  // Effect of one clock edge, written from the packet rules.
  task automatic model_step(input logic vld, input logic [2:0] hdr, input logic [32:0] d,
                            input logic rdy, input logic clr);
    logic        s;
    logic [31:0] v;
    qcom_cmd_t   c;
    int          dly;
`ifdef QCOM_SYNC_DLY_EN
    dly = int'(sync_dly_cfg);
`else
    dly = 0;
`endif
    if (clr) begin
      model_reset();
      return;
    end
    if (m_occ > 0 && rdy) m_occ--;
    if (!vld) return;
    if (hdr == 3'b101 || hdr == 3'b111) begin
      m_err = sat(m_err);
      return;
    end
    s = 1'b0; v = 32'd0;
    if (hdr == 3'b010)      begin s = d[8];  v = d[31:0] & 32'hFF;   end
    else if (hdr == 3'b011) begin s = d[8];                           end
    else if (hdr == 3'b100) begin s = d[17]; v = d[31:0] & 32'hFFFF; end
    else if (hdr == 3'b110) begin s = d[32]; v = d[31:0];             end
    m_rx = sat(m_rx);
    if (hdr == 3'b000) m_flag = 1'b0;
    if (hdr == 3'b001) m_flag = 1'b1;
    if (hdr == 3'b010 || hdr == 3'b100 || hdr == 3'b110) begin
      if (s) m_r2 = v; else m_r1 = v;
    end
    if (hdr == 3'b011) m_due = cyc + 1 + dly;
    if (m_occ < DEPTH) begin
      c = {hdr, s, v};
      exp_q.push_back(c);
      m_occ++;
    end else begin
      m_drop = sat(m_drop);
    end
  endtask

  task automatic drive(input logic vld, input logic [2:0] hdr, input logic [32:0] d,
                       input logic rdy, input logic clr);
    bus.rx_vld_i = vld; bus.rx_header_i = hdr; bus.rx_data_i = d;
    bus.cmd_rdy_i = rdy; clr_i = clr;
    @(negedge c_clk_i);
    check_state();
    #1;
    model_step(vld, hdr, d, rdy, clr);
    @(posedge c_clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 3'b000, 33'd0, rdy, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle, held across two edges.
  task automatic do_reset();
    bus.rx_vld_i = 1'b0; bus.cmd_rdy_i = 1'b0; clr_i = 1'b0;
    #2 c_rst_ni = 1'b0;
    #1;
    chk("rst_sync", 64'(sync_o), 64'd0);
    chk("rst_vld",  64'(bus.cmd_vld_o), 64'd0);
    chk("rst_flag", 64'(qflag_o), 64'd0);
    model_reset();
    @(negedge c_clk_i);
    @(negedge c_clk_i);
    c_rst_ni = 1'b1;
    @(posedge c_clk_i);
    #1;
    cyc++;
  endtask

  // Scoreboard: every handshake on the command output consumes one expected entry.
  initial begin
    qcom_cmd_t e;
    forever begin
      @(negedge c_clk_i);
      if (c_rst_ni && bus.cmd_vld_o && bus.cmd_rdy_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: got %0h expected nothing (cycle %0d)",
                   {bus.cmd_op_o, bus.cmd_sel_o, bus.cmd_dt_o}, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_head", 64'({bus.cmd_op_o, bus.cmd_sel_o, bus.cmd_dt_o}), 64'(e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses, at, exp_pulses, exp_at;
    logic [32:0] d;
    logic [2:0]  h;
    bus.rx_vld_i = 1'b0; bus.rx_header_i = '0; bus.rx_data_i = '0; bus.cmd_rdy_i = 1'b0;
    model_reset();
    repeat (2) @(negedge c_clk_i);
    chk("reset_qreg1", 64'(qreg1_o), 64'd0);
    chk("reset_qreg2", 64'(qreg2_o), 64'd0);
    chk("reset_rx",    64'(rx_cnt_o), 64'd0);
    chk("reset_head",  64'({bus.cmd_op_o, bus.cmd_sel_o, bus.cmd_dt_o}), 64'd0);
    c_rst_ni = 1'b1;
    @(posedge c_clk_i);
    #1;

    // Flag set / clear
    drive(1'b1, 3'b001, 33'd0, 1'b1, 1'b0);
    chk("flag_set", 64'(qflag_o), 64'd1);
    drive(1'b1, 3'b000, 33'd0, 1'b1, 1'b0);
    chk("flag_clr", 64'(qflag_o), 64'd0);
    chk("rx_two",   64'(rx_cnt_o), 64'd2);

    // 8-bit write into register 2
    drive(1'b1, 3'b010, 33'h0_0000_01A5, 1'b1, 1'b0);
    chk("dt8_qreg2", 64'(qreg2_o), 64'h0000_00A5);
    chk("dt8_qreg1", 64'(qreg1_o), 64'd0);
    repeat (3) idle(1'b1);

    // 32-bit write into register 1, head stays visible with rdy low
    drive(1'b1, 3'b110, 33'h0_DEAD_BEEF, 1'b0, 1'b0);
    chk("dt32_qreg1", 64'(qreg1_o), 64'hDEAD_BEEF);
    chk("dt32_head", 64'({bus.cmd_vld_o, bus.cmd_op_o, bus.cmd_sel_o, bus.cmd_dt_o}),
        64'({1'b1, 3'b110, 1'b0, 32'hDEAD_BEEF}));
    repeat (3) idle(1'b1);

    // Overflow: five packets into a four-deep queue, then drain in order
    for (int i = 0; i < 5; i++) drive(1'b1, 3'b100, 33'(32'h1000 + i), 1'b0, 1'b0);
    chk("ovf_drop", 64'(drop_cnt_o), 64'd1);
    repeat (6) idle(1'b1);

    // Undefined header
    drive(1'b1, 3'b101, 33'h1_FFFF_FFFF, 1'b1, 1'b0);
    chk("err_one", 64'(err_cnt_o), 64'd1);
    chk("err_nopush", 64'(bus.cmd_vld_o), 64'd0);

    // SYNC timing
    sync_dly_cfg = 8'd5;
`ifdef QCOM_SYNC_DLY_EN
    exp_at = 5;
`else
    exp_at = 0;
`endif
    drive(1'b1, 3'b011, 33'd0, 1'b1, 1'b0);
    pulses = 0; at = -1;
    for (int k = 0; k < 10; k++) begin
      if (sync_o) begin pulses++; at = k; end
      idle(1'b1);
    end
    chk("sync_single_n", 64'(pulses), 64'd1);
    chk("sync_single_at", 64'(at), 64'(exp_at));

    // Retrigger three cycles after the first strobe
`ifdef QCOM_SYNC_DLY_EN
    exp_pulses = 1; exp_at = 8;
`else
    exp_pulses = 2; exp_at = 3;
`endif
    drive(1'b1, 3'b011, 33'd0, 1'b1, 1'b0);
    pulses = 0; at = -1;
    for (int k = 0; k < 14; k++) begin
      if (sync_o) begin pulses++; at = k; end
      if (k == 2) drive(1'b1, 3'b011, 33'h100, 1'b1, 1'b0);
      else        idle(1'b1);
    end
    chk("sync_retrig_n", 64'(pulses), 64'(exp_pulses));
    chk("sync_retrig_at", 64'(at), 64'(exp_at));

    // clr during the wait
    drive(1'b1, 3'b011, 33'd0, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    drive(1'b0, 3'b000, 33'd0, 1'b1, 1'b1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (sync_o) pulses++;
      idle(1'b1);
    end
    chk("sync_clr_none", 64'(pulses), 64'd0);

    // Async reset during the wait
    drive(1'b1, 3'b011, 33'd0, 1'b1, 1'b0);
    idle(1'b1);
    do_reset();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (sync_o) pulses++;
      idle(1'b1);
    end
    chk("sync_rst_none", 64'(pulses), 64'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic v, r, c;
      if (i % 100 == 0) sync_dly_cfg = 8'($urandom_range(0, 7));
      v = 1'($urandom_range(0, 1));
      h = 3'($urandom_range(0, 7));
      d[31:0] = $urandom;
      d[32] = 1'($urandom_range(0, 1));
      r = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 63) == 0);
      drive(v, h, d, r, c);
    end

    repeat (8) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
